// File: rtl/adder_exerciser_pkg.sv
// Shared types and constants for the adder exerciser: FSM states, LFSR taps per width, seed default.
package adder_exerciser_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_e;

  // A zero seed would lock the LFSR, so it is replaced by this value.
  localparam int unsigned SEED_DEFAULT = 1;

  // Maximal-length Fibonacci tap masks indexed by LFSR length (bit n-1 = tap n).
  function automatic logic [63:0] lfsr_taps(input int unsigned lw);
    case (lw)
      8:       return 64'h0000_0000_0000_00B8;  // 8,6,5,4
      16:      return 64'h0000_0000_0000_B400;  // 16,14,13,11
      24:      return 64'h0000_0000_00E1_0000;  // 24,23,22,17
      32:      return 64'h0000_0000_8020_0003;  // 32,22,2,1
      default: return 64'h0000_0000_0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/exerciser_lfsr.sv
// Fibonacci LFSR with seed load (zero seed substituted) and step enable; exposes the next state.
module exerciser_lfsr
  import adder_exerciser_pkg::*;
#(
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [LW-1:0] seed,
  input  logic          step,
  output logic [LW-1:0] nxt
);

  localparam logic [LW-1:0] TAPS = LW'(lfsr_taps(LW));

  logic [LW-1:0] q;

  always_comb begin
    nxt = q;
    if (load)
      nxt = (seed == '0) ? LW'(SEED_DEFAULT) : seed;
    else if (step)
      nxt = {q[LW-2:0], ^(q & TAPS)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= nxt;
  end

endmodule

// File: rtl/adder_exerciser.sv
// Drives registered operands into an adder under test, waits a settle time, captures and checks the sum.
module adder_exerciser
  import adder_exerciser_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SETTLE_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [WIDTH-1:0]    a_load,
  input  logic [WIDTH-1:0]    b_load,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0]    num_vectors,
  output logic [WIDTH-1:0]    a_out,
  output logic [WIDTH-1:0]    b_out,
  input  logic [WIDTH-1:0]    sum_in,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result_sum,
  output logic                mismatch,
  output logic [CNT_W-1:0]    vec_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam int LW = 2 * WIDTH;

  state_e              state, state_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_r;
  logic                mode_r;
  logic [CNT_W-1:0]    nvec_r;
  logic [CNT_W-1:0]    vec_inc;
  logic [WIDTH-1:0]    ref_sum;
  logic                cap_bad, last_vec;
  logic                lfsr_load, lfsr_step;
  logic [LW-1:0]       lfsr_nxt;

  // Carry is dropped: the adders under test have no carry out.
  assign ref_sum   = a_out + b_out;
  assign cap_bad   = (sum_in != ref_sum);
  assign vec_inc   = vec_count + CNT_W'(1);
  assign last_vec  = !mode_r || (vec_inc == nvec_r);
  assign lfsr_load = (state == IDLE) && start && mode;
  assign lfsr_step = (state == CAPTURE) && !last_vec;

  assign busy = (state == SETTLE) || (state == CAPTURE);
  assign done = (state == DONE);

  exerciser_lfsr #(.LW(LW)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  ({a_load, b_load}),
    .step  (lfsr_step),
    .nxt   (lfsr_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = last_vec ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out      <= '0;
      b_out      <= '0;
      result_sum <= '0;
      mismatch   <= 1'b0;
      vec_count  <= '0;
      err_count  <= '0;
      settle_cnt <= '0;
      settle_r   <= '0;
      mode_r     <= 1'b0;
      nvec_r     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_r     <= mode;
          nvec_r     <= (num_vectors == '0) ? CNT_W'(1) : num_vectors;
          settle_r   <= settle_cycles;
          settle_cnt <= settle_cycles;
          vec_count  <= '0;
          err_count  <= '0;
          mismatch   <= 1'b0;
          if (mode) {a_out, b_out} <= lfsr_nxt;
          else      {a_out, b_out} <= {a_load, b_load};
        end
        SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
        CAPTURE: begin
          result_sum <= sum_in;
          vec_count  <= vec_inc;
          if (cap_bad) begin
            mismatch <= 1'b1;
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
          end
          if (!last_vec) begin
            {a_out, b_out} <= lfsr_nxt;
            settle_cnt     <= settle_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_exerciser.sv
// Scoreboard bench: issue runs, push the model's expected result, monitor compares on each done pulse.
module tb_adder_exerciser;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, fault = 1'b0;
  logic [7:0]  a_load = '0, b_load = '0;
  logic [3:0]  settle_cycles = '0;
  logic [15:0] num_vectors = '0;
  logic [7:0]  a_out, b_out, sum_in, result_sum;
  logic        busy, done, mismatch;
  logic [15:0] vec_count, err_count;

  // Adder under test, with an optional stuck-at-0 fault on bit 0.
  assign sum_in = fault ? (8'(a_out + b_out) & 8'hFE) : 8'(a_out + b_out);

  adder_exerciser #(.WIDTH(8), .SETTLE_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .a_load(a_load), .b_load(b_load), .settle_cycles(settle_cycles),
    .num_vectors(num_vectors), .a_out(a_out), .b_out(b_out), .sum_in(sum_in),
    .busy(busy), .done(done), .result_sum(result_sum), .mismatch(mismatch),
    .vec_count(vec_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  sum;
    logic        mism;
    logic [15:0] vc, ec;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) chk("done_without_start", done, 0);
      else begin
        mon_e = sb.pop_front();
        chk("result_sum", result_sum, mon_e.sum);
        chk("mismatch",   mismatch,   mon_e.mism);
        chk("vec_count",  vec_count,  mon_e.vc);
        chk("err_count",  err_count,  mon_e.ec);
        chk("done_cycle", cyc,        mon_e.cyc);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && !done) return;
      @(posedge clk); #1;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    chk("done_timeout", sb.size(), 0);
    sb.delete();
  endtask

  // Model the whole run from the behavioural rules, then launch it.
  task automatic issue(input bit md, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] s, input logic [15:0] n, input bit flt);
    exp_t        e;
    logic [15:0] st;
    logic [7:0]  r, g, fa, fb;
    int          nv;
    nv = md ? ((n == 0) ? 1 : int'(n)) : 1;
    st = (md && {a, b} == 16'h0) ? 16'h0001 : {a, b};
    fa = st[15:8]; fb = st[7:0];
    e.ec = 0; e.mism = 1'b0; e.sum = '0;
    for (int i = 0; i < nv; i++) begin
      r = 8'((int'(st[15:8]) + int'(st[7:0])) % 256);
      g = flt ? (r & 8'hFE) : r;
      if (g != r) begin e.mism = 1'b1; e.ec++; end
      e.sum = g;
      st = lfsr_next(st);
    end
    e.vc = 16'(nv);
    wait_idle();
    mode = md; a_load = a; b_load = b; settle_cycles = s; num_vectors = n; fault = flt;
    start = 1'b1;
    e.cyc = cyc + 1 + nv * (int'(s) + 2);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_a_out", a_out, fa);
    chk("first_b_out", b_out, fb);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_out"}, a_out, 0);
    chk({tag, "_b_out"}, b_out, 0);
    chk({tag, "_result_sum"}, result_sum, 0);
    chk({tag, "_vec_count"}, vec_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_flags"}, {busy, done, mismatch}, 0);
  endtask

  initial begin
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed: single vector, wrap-around with max settle, stuck-bit sweep, zero seed/zero count.
    issue(0, 8'h5A, 8'hA5, 4'd0, 16'd0, 0);   drain();
    issue(0, 8'hFF, 8'h01, 4'd15, 16'd0, 0);  drain();
    issue(1, 8'h12, 8'h34, 4'd2, 16'd100, 1); drain();
    issue(1, 8'h00, 8'h00, 4'd1, 16'd0, 0);   drain();

    // Reset during the settle of vector 3 of a sweep.
    issue(1, 8'hBE, 8'hEF, 4'd3, 16'd10, 0);
    for (int i = 0; i < 200; i++) begin
      if (vec_count == 16'd2 && busy) break;
      @(posedge clk); #1;
    end
    chk("reached_vector3", {busy, vec_count}, {1'b1, 16'd2});
    @(negedge clk);
    reset = 1'b1;
    #1 check_zero("midrun_reset");
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    issue(0, 8'h5A, 8'hA5, 4'd0, 16'd0, 0);   drain();

    // start pulses during SETTLE, CAPTURE and DONE must be ignored.
    issue(0, 8'h12, 8'h34, 4'd5, 16'd0, 0);
    mode = 1'b1; a_load = 8'hEE; b_load = 8'hEE; settle_cycles = 4'd0; num_vectors = 16'd7;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("a_out_hold_settle", {a_out, b_out}, 16'h1234);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    chk("idle_after_done", {busy, done}, 0);
    drain();
    repeat (4) @(posedge clk);
    #1 chk("no_restart", busy, 0);

    // Randomised singles and sweeps.
    for (int i = 0; i < 6; i++) begin
      issue(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 16'd0, 1'($urandom));
      drain();
    end
    for (int i = 0; i < 4; i++) begin
      issue(1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)),
            16'($urandom_range(1, 60)), 1'($urandom));
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
